// File: rtl/frogger_pkg.sv
// Shared constants for the frogger lane generator: screen/object geometry, per-lane
// placement, speed and direction, plus the log displacement encoding helper.
package frogger_pkg;

   localparam int unsigned NUM_LANES = 3;

   localparam int unsigned SCREEN_W  = 640;
   localparam int unsigned CAR_W     = 32;
   localparam int unsigned LOG_W     = 96;
   localparam int unsigned CAR_WRAP  = SCREEN_W + CAR_W;   // 672
   localparam int unsigned LOG_WRAP  = SCREEN_W + LOG_W;   // 736
   localparam int unsigned CAR_STEP  = 2;
   localparam int unsigned LOG_STEP  = 1;

   typedef logic [10:0]        coord_t;
   typedef logic signed [2:0]  dx_t;

   // Packed arrays are listed {lane 2, lane 1, lane 0}.
   localparam logic [NUM_LANES-1:0][10:0] LANE_Y_CAR  = {11'd352, 11'd384, 11'd416};
   localparam logic [NUM_LANES-1:0][10:0] LANE_Y_LOG  = {11'd128, 11'd160, 11'd192};
   localparam logic [NUM_LANES-1:0][10:0] LANE_X0_CAR = {11'd650, 11'd30,  11'd100};
   localparam logic [NUM_LANES-1:0][10:0] LANE_X0_LOG = {11'd20,  11'd700, 11'd40};

   localparam logic [NUM_LANES-1:0][3:0]  LANE_PERIOD_CAR = {4'd3, 4'd2, 4'd1};
   localparam logic [NUM_LANES-1:0][3:0]  LANE_PERIOD_LOG = {4'd3, 4'd1, 4'd2};

   // 1 = moves right; directions alternate lane to lane.
   localparam logic [NUM_LANES-1:0] LANE_DIR_CAR = 3'b101;
   localparam logic [NUM_LANES-1:0] LANE_DIR_LOG = 3'b010;

   // Signed per-move displacement in the 3-bit Log_dx encoding.
   function automatic logic [2:0] dir_step(input logic dir, input int unsigned step);
      logic [2:0] w_s;
      w_s = step[2:0];
      return dir ? w_s : (3'd0 - w_s);
   endfunction

endpackage

// File: rtl/lane_obstacles_if.sv
// Bundle between lane_obstacles and its consumers (color_mapper, frog): the vs/run
// controls going in and all lane geometry coming out.
interface lane_obstacles_if;
   import frogger_pkg::*;

   logic                          vs;
   logic                          run;
   logic                          frame_tick;
   logic [NUM_LANES-1:0][10:0]    Car_X;
   logic [NUM_LANES-1:0][10:0]    Car_Y;
   logic [NUM_LANES-1:0][10:0]    Log_X;
   logic [NUM_LANES-1:0][10:0]    Log_Y;
   logic [10:0]                   Car_size;
   logic [10:0]                   Log_size;
   logic [NUM_LANES-1:0][2:0]     Log_dx;

   // Lane generator side.
   modport master (
      input  vs, run,
      output frame_tick, Car_X, Car_Y, Log_X, Log_Y, Car_size, Log_size, Log_dx
   );

   // Consumer side (also drives the controls).
   modport slave (
      output vs, run,
      input  frame_tick, Car_X, Car_Y, Log_X, Log_Y, Car_size, Log_size, Log_dx
   );

endinterface

// File: rtl/lane_obstacles_mover.sv
// One lane: a period counter that advances on frame ticks while running, and a
// position that steps by STEP in direction DIR, wrapping modulo WRAP, each time the
// counter rolls over.
module lane_mover
   import frogger_pkg::*;
#(
   parameter int unsigned STEP   = 1,
   parameter int unsigned WRAP   = 736,
   parameter int unsigned PERIOD = 1,
   parameter logic        DIR    = 1'b1,
   parameter logic [10:0] X0     = 11'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_tick,
   input  logic        i_run,
   output logic [10:0] o_x,
   output logic        o_moved
);

   localparam logic [10:0] P_STEP = 11'(STEP);
   localparam logic [10:0] P_WRAP = 11'(WRAP);
   localparam logic [3:0]  P_LAST = 4'(PERIOD - 1);

   // Wrap arithmetic below relies on these to keep X inside [0, WRAP-1].
   generate
      if (STEP >= WRAP || 32'(X0) >= WRAP || PERIOD < 1 || PERIOD > 15 || WRAP > 2047)
      begin : g_bad_params
         $error("lane_mover: illegal STEP/WRAP/PERIOD/X0 combination");
      end
   endgenerate

   logic [3:0]  r_cnt;
   logic [10:0] r_x;
   logic [10:0] w_x_next;
   logic        w_move;

   assign w_move = i_tick & i_run & (r_cnt == P_LAST);

   // Candidate next position, one step with modular wrap.
   always_comb begin
      w_x_next = r_x;
      if (DIR) begin
         if (r_x + P_STEP >= P_WRAP) begin
            w_x_next = r_x + P_STEP - P_WRAP;
         end else begin
            w_x_next = r_x + P_STEP;
         end
      end else begin
         if (r_x < P_STEP) begin
            w_x_next = r_x + P_WRAP - P_STEP;
         end else begin
            w_x_next = r_x - P_STEP;
         end
      end
   end

   // Period counter and position; both frozen when not running.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 4'd0;
         r_x   <= X0;
      end else if (i_tick && i_run) begin
         if (r_cnt == P_LAST) begin
            r_cnt <= 4'd0;
            r_x   <= w_x_next;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   assign o_x     = r_x;
   assign o_moved = w_move;

endmodule

// File: rtl/lane_obstacles.sv
// Frame-rate lane generator: synchronises VGA vs, turns each falling edge into a
// one-cycle frame tick, and steps three car lanes and three log lanes on that tick.
// Log_dx reports how far each log moved so the frog can ride it.
module lane_obstacles
   import frogger_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   lane_obstacles_if.master bus
);

   logic                         r_sync1;
   logic                         r_sync2;
   logic                         r_prev;
   logic                         r_tick;
   logic                         w_fall;
   logic [NUM_LANES-1:0][10:0]   w_car_x;
   logic [NUM_LANES-1:0][10:0]   w_log_x;
   logic [NUM_LANES-1:0]         w_unused_car_moved;
   logic [NUM_LANES-1:0]         w_log_moved;
   logic [NUM_LANES-1:0][2:0]    r_log_dx;

   // Two-flop synchroniser for vs plus a delayed copy for edge detection; idle high.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= bus.vs;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Lanes step on the same edge that raises frame_tick, so positions change in the tick cycle.
   assign w_fall = r_prev & ~r_sync2;

   // Registered frame tick, one cycle per synchronised falling edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_fall;
      end
   end

   generate
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         lane_mover #(
            .STEP   (CAR_STEP),
            .WRAP   (CAR_WRAP),
            .PERIOD (32'(LANE_PERIOD_CAR[i])),
            .DIR    (LANE_DIR_CAR[i]),
            .X0     (LANE_X0_CAR[i])
         ) u_car (
            .i_clk   (Clk),
            .i_rst   (Reset),
            .i_tick  (w_fall),
            .i_run   (bus.run),
            .o_x     (w_car_x[i]),
            .o_moved (w_unused_car_moved[i])
         );

         lane_mover #(
            .STEP   (LOG_STEP),
            .WRAP   (LOG_WRAP),
            .PERIOD (32'(LANE_PERIOD_LOG[i])),
            .DIR    (LANE_DIR_LOG[i]),
            .X0     (LANE_X0_LOG[i])
         ) u_log (
            .i_clk   (Clk),
            .i_rst   (Reset),
            .i_tick  (w_fall),
            .i_run   (bus.run),
            .o_x     (w_log_x[i]),
            .o_moved (w_log_moved[i])
         );
      end
   endgenerate

   // Log displacement, aligned with frame_tick and cleared the cycle after.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_log_dx <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            r_log_dx[i] <= w_log_moved[i] ? dir_step(LANE_DIR_LOG[i], LOG_STEP) : 3'd0;
         end
      end
   end

   assign bus.frame_tick = r_tick;
   assign bus.Car_X      = w_car_x;
   assign bus.Log_X      = w_log_x;
   assign bus.Log_dx     = r_log_dx;
   assign bus.Car_Y      = LANE_Y_CAR;
   assign bus.Log_Y      = LANE_Y_LOG;
   assign bus.Car_size   = 11'(CAR_W);
   assign bus.Log_size   = 11'(LOG_W);

endmodule

// File: tb/tb_lane_obstacles.sv
// Bench for lane_obstacles: random vs/run/reset traffic checked every cycle against a
// lane-position model, plus directed literal checks of latency, wrap, freeze and dx.
module tb_lane_obstacles;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lane_obstacles_if u_if ();

   lane_obstacles u_dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (u_if.master)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model lanes 0..2 are cars, 3..5 are logs.
   int m_x0[6]   = '{100, 30, 650, 40, 700, 20};
   int m_per[6]  = '{1, 2, 3, 2, 1, 3};
   int m_dir[6]  = '{1, -1, 1, -1, 1, -1};
   int m_step[6] = '{2, 2, 2, 1, 1, 1};
   int m_wrap[6] = '{672, 672, 672, 736, 736, 736};
   int m_pos[6];
   int m_cnt[6];
   bit vs_hist[3];          // vs seen at the last three rising edges, newest first
   bit exp_tick;
   int exp_dx[3];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int wrap_add(input int x, input int d, input int w);
      return ((x + d) % w + w) % w;
   endfunction

   // Model and compare: inputs change only at negedge+2, so at a negedge they still
   // hold what the DUT saw at the preceding rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int k = 0; k < 3; k++) vs_hist[k] = 1'b1;
            exp_tick = 1'b0;
            for (int l = 0; l < 6; l++) begin
               m_pos[l] = m_x0[l];
               m_cnt[l] = 0;
            end
            for (int l = 0; l < 3; l++) exp_dx[l] = 0;
         end else begin
            // A vs fall reaches frame_tick after the sync chain: high two edges back, low one back.
            exp_tick = vs_hist[1] && !vs_hist[0] ? 1'b0 : 1'b0;
            exp_tick = vs_hist[2] && !vs_hist[1];
            for (int l = 0; l < 3; l++) exp_dx[l] = 0;
            if (exp_tick && u_if.run) begin
               for (int l = 0; l < 6; l++) begin
                  if (m_cnt[l] == m_per[l] - 1) begin
                     m_cnt[l] = 0;
                     m_pos[l] = wrap_add(m_pos[l], m_dir[l] * m_step[l], m_wrap[l]);
                     if (l >= 3) exp_dx[l-3] = m_dir[l];
                  end else begin
                     m_cnt[l]++;
                  end
               end
            end
            vs_hist[2] = vs_hist[1];
            vs_hist[1] = vs_hist[0];
            vs_hist[0] = u_if.vs;

            check("frame_tick", int'(u_if.frame_tick), int'(exp_tick));
            for (int l = 0; l < 3; l++) begin
               check($sformatf("Car_X[%0d]", l), int'(u_if.Car_X[l]), m_pos[l]);
               check($sformatf("Log_X[%0d]", l), int'(u_if.Log_X[l]), m_pos[l+3]);
               check($sformatf("Log_dx[%0d]", l), int'($signed(u_if.Log_dx[l])), exp_dx[l]);
            end
         end
      end
   end

   task automatic set_in(input bit v, input bit r);
      @(negedge clk);
      #2;
      u_if.vs  = v;
      u_if.run = r;
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drop vs and wait (bounded) for the tick; returns negedges taken.
   task automatic tick_once(input bit r, output int lat);
      bit found;
      set_in(1'b0, r);
      found = 1'b0;
      lat = 0;
      for (int k = 1; k <= 30 && !found; k++) begin
         @(negedge clk);
         #1;
         if (u_if.frame_tick) begin
            found = 1'b1;
            lat = k;
         end
      end
      if (!found) check("tick_timeout", 0, 1);
   endtask

   task automatic end_frame(input bit r);
      set_in(1'b1, r);
      hold(4);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      for (int l = 0; l < 3; l++) begin
         check($sformatf("rst_Car_X[%0d]", l), int'(u_if.Car_X[l]), m_x0[l]);
         check($sformatf("rst_Log_X[%0d]", l), int'(u_if.Log_X[l]), m_x0[l+3]);
         check($sformatf("rst_Log_dx[%0d]", l), int'(u_if.Log_dx[l]), 0);
      end
      check("rst_frame_tick", int'(u_if.frame_tick), 0);
      hold(2);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      u_if.vs  = 1'b1;
      u_if.run = 1'b1;
      hold(3);
      #3;
      rst = 1'b0;
      hold(4);

      // Constant geometry.
      check("Car_size", int'(u_if.Car_size), 32);
      check("Log_size", int'(u_if.Log_size), 96);
      check("Car_Y[0]", int'(u_if.Car_Y[0]), 416);
      check("Log_Y[2]", int'(u_if.Log_Y[2]), 128);
      check("reset_Car_X0", int'(u_if.Car_X[0]), 100);

      // Tick 1: latency and first moves.
      tick_once(1'b1, lat);
      check("tick_latency", lat, 3);
      check("t1_Car_X0", int'(u_if.Car_X[0]), 102);
      check("t1_Log_X1", int'(u_if.Log_X[1]), 701);
      check("t1_Log_dx1", int'(u_if.Log_dx[1]), 3'b001);
      check("t1_Log_dx0", int'(u_if.Log_dx[0]), 0);
      @(negedge clk);
      #1;
      check("t1_tick_one_cycle", int'(u_if.frame_tick), 0);
      check("t1_dx_cleared", int'(u_if.Log_dx[1]), 0);
      end_frame(1'b1);

      // Tick 2: left log lane with period 2 moves, reported as -1.
      tick_once(1'b1, lat);
      check("t2_Log_X0", int'(u_if.Log_X[0]), 39);
      check("t2_Log_dx0", int'(u_if.Log_dx[0]), 3'b111);
      check("t2_Car_X1", int'(u_if.Car_X[1]), 28);
      end_frame(1'b1);

      // Tick 3: period-3 car lane moves for the first time.
      tick_once(1'b1, lat);
      check("t3_Car_X2", int'(u_if.Car_X[2]), 652);
      check("t3_Car_X0", int'(u_if.Car_X[0]), 106);
      end_frame(1'b1);

      // Tick 4 with run=0: tick still pulses, nothing moves.
      tick_once(1'b0, lat);
      check("t4_frozen_tick_latency", lat, 3);
      check("t4_Car_X0", int'(u_if.Car_X[0]), 106);
      check("t4_Log_dx1", int'(u_if.Log_dx[1]), 0);
      end_frame(1'b1);

      // Tick 5: counters resumed where they were frozen.
      tick_once(1'b1, lat);
      check("t5_Car_X0", int'(u_if.Car_X[0]), 108);
      check("t5_Car_X2", int'(u_if.Car_X[2]), 652);
      end_frame(1'b1);

      // Random frames, glitches, run toggling and rare resets.
      for (int f = 0; f < 700; f++) begin
         bit r;
         int lo;
         int hi;
         r  = ($urandom_range(0, 3) != 0);
         lo = $urandom_range(1, 6);
         hi = $urandom_range(1, 10);
         if ($urandom_range(0, 299) == 0) pulse_reset();
         set_in(1'b0, r);
         hold(lo - 1);
         set_in(1'b1, r);
         hold(hi - 1);
      end

      // Reset from a non-initial state clears immediately.
      set_in(1'b1, 1'b1);
      hold(4);
      pulse_reset();
      hold(3);

      // Long vs low: exactly one tick.
      set_in(1'b0, 1'b1);
      cnt = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         #1;
         if (u_if.frame_tick) cnt++;
      end
      check("long_low_ticks", cnt, 1);

      // One-cycle glitch low: exactly one tick.
      set_in(1'b1, 1'b1);
      hold(5);
      set_in(1'b0, 1'b1);
      set_in(1'b1, 1'b1);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (u_if.frame_tick) cnt++;
      end
      check("glitch_ticks", cnt, 1);

      hold(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
